mod_mul_pipe: RTL and testbench

Pipelined modular multiplier for the NTT butterfly datapath. It takes two 12-bit operands, forms their 24-bit product and returns the product reduced modulo 3329 (Barrett method). It is the producer-side counterpart of the combinational Barrett reducer: it generates the wide products and owns their reduction, with valid/ready flow control. It sits between the twiddle/coefficient fetch logic and the butterfly add/sub stage.

---
 rtl/mod_mul_pipe.sv | 157 +++++++++++++++
 tb/tb_mod_mul_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_pipe.sv
// -----------------------------------------------------------------------------
// mod_mul_pipe
//
// Pipelined modular multiplier for the NTT butterfly datapath. Forms the 24-bit
// product of two 12-bit operands and reduces it modulo Q (3329) with Barrett
// reduction over three register stages:
//   S1: c = a*b, tag, range flag
//   S2: t = (c*BARRETT_M) >> 24, r = c - t*Q   (r < 3Q)
//   S3: r minus 0, Q or 2Q -> out_data in 0..Q-1
//
// Handshake: a transfer happens on every rising edge where valid && ready is 1,
// on both the input and the output port. The producer holds in_valid and its
// payload until the transfer happens. in_ready depends only on out_ready and
// the stage valid bits and never on in_valid. Each stage loads when it is empty
// or when its content moves on in the same cycle, so bubbles collapse and a
// full pipeline shifts as a whole when out_ready is 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; discards all in-flight work
//   in_valid   operand pair present
//   in_ready   block accepts the pair this cycle
//   in_a/in_b  12-bit operands (any value)
//   in_tag     sideband tag, returned unchanged with the result
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out_data   (a*b) mod Q
//   out_tag    tag of this result
//   out_err    operand range flag
//
// Optional feature: define MOD_MUL_RANGE_CHECK_EN to flag operands >= Q on
// out_err. Without it no compare logic is built and out_err is always 0.
// -----------------------------------------------------------------------------
module mod_mul_pipe #(
    parameter int Q         = 3329,
    parameter int BARRETT_M = 5039,
    parameter int TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_a,
    input  logic [11:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Stage registers
    logic             s1_valid;
    logic [23:0]      s1_c;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_err;

    logic             s2_valid;
    logic [13:0]      s2_r;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_err;

    logic             s3_valid;
    logic [11:0]      s3_data;
    logic [TAG_W-1:0] s3_tag;
    logic             s3_err;

    // Per-stage "can load this cycle" terms, chained back from the output.
    logic s1_ready;
    logic s2_ready;
    logic s3_ready;

    assign s3_ready = !s3_valid || out_ready;
    assign s2_ready = !s2_valid || s3_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // Operand range flag
    logic in_err;
`ifdef MOD_MUL_RANGE_CHECK_EN
    assign in_err = (in_a >= 12'(Q)) || (in_b >= 12'(Q));
`else
    assign in_err = 1'b0;
`endif

    // S2 combinational Barrett step. c < 2^24 and BARRETT_M < 2^13, so the
    // product needs 37 bits; the quotient estimate t fits in 13 bits. t may
    // undershoot the true quotient by up to 2, hence r < 3Q which fits 14 bits.
    logic [12:0] s2_t_next;
    logic [13:0] s2_r_next;

    assign s2_t_next = 13'((37'(s1_c) * 37'(BARRETT_M)) >> 24);
    assign s2_r_next = 14'(s1_c - 24'(s2_t_next) * 24'(Q));

    // S3 combinational final correction
    logic [11:0] s3_data_next;

    always_comb begin
        s3_data_next = s2_r[11:0];
        if (s2_r >= 14'(2 * Q)) begin
            s3_data_next = 12'(s2_r - 14'(2 * Q));
        end else if (s2_r >= 14'(Q)) begin
            s3_data_next = 12'(s2_r - 14'(Q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_c     <= '0;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_tag   <= '0;
            s3_err   <= 1'b0;
        end else begin
            // Payload registers only load with valid content, so the
            // presented result stays stable while the output is stalled.
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_c   <= 24'(in_a) * 24'(in_b);
                    s1_tag <= in_tag;
                    s1_err <= in_err;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_r   <= s2_r_next;
                    s2_tag <= s1_tag;
                    s2_err <= s1_err;
                end
            end
            if (s3_ready) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_data <= s3_data_next;
                    s3_tag  <= s2_tag;
                    s3_err  <= s2_err;
                end
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_data  = s3_data;
    assign out_tag   = s3_tag;
    assign out_err   = s3_err;

endmodule

// File: tb/tb_mod_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_mod_mul_pipe: self-checking bench for mod_mul_pipe.
// Directed corner vectors from a table with latency checks, back-to-back
// streaming, backpressure, random valid/ready traffic and mid-flight reset.
// A negedge scoreboard (exp_q) checks every output transfer in order and that
// stalled outputs hold stable.
// -----------------------------------------------------------------------------
module tb_mod_mul_pipe;

    localparam int Q     = 3329;
    localparam int TAG_W = 8;

`ifdef MOD_MUL_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [11:0]      in_a = '0;
    logic [11:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [11:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    mod_mul_pipe #(.Q(3329), .BARRETT_M(5039), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {err, tag, data}
    function automatic logic [20:0] model(input logic [11:0] a, input logic [11:0] b,
                                          input logic [7:0] tag);
        logic [11:0] d;
        logic        e;
        d = 12'((int'(a) * int'(b)) % Q);
        e = RANGE_EN && ((a >= 12'(Q)) || (b >= 12'(Q)));
        return {e, tag, d};
    endfunction

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [20:0] held = '0;

    always @(negedge clk) begin
        logic [20:0] e;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_payload", 32'({out_err, out_tag, out_data}), 32'(held));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data %0d tag %0d with empty queue (t=%0t)",
                             out_data, out_tag, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 32'({out_err, out_tag, out_data}), 32'(e));
                end
            end
            hold_pending = out_valid && !out_ready;
            held = {out_err, out_tag, out_data};
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_tag));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1ns after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [7:0] tag);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = tag;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles (t=%0t)", $time);
        in_valid = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [7:0]  tag;
        logic [11:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int start_cyc;
        int start_out;

        vecs[0] = '{a: 12'd3328, b: 12'd3328, tag: 8'h11, exp_data: 12'd1,    exp_err: 1'b0};
        vecs[1] = '{a: 12'd0,    b: 12'd2000, tag: 8'h22, exp_data: 12'd0,    exp_err: 1'b0};
        vecs[2] = '{a: 12'd1,    b: 12'd1234, tag: 8'h33, exp_data: 12'd1234, exp_err: 1'b0};
        vecs[3] = '{a: 12'd17,   b: 12'd196,  tag: 8'h44, exp_data: 12'd3,    exp_err: 1'b0};
        vecs[4] = '{a: 12'd2000, b: 12'd3000, tag: 8'h55, exp_data: 12'd1142, exp_err: 1'b0};
        vecs[5] = '{a: 12'd3329, b: 12'd1,    tag: 8'h66, exp_data: 12'd0,    exp_err: RANGE_EN};
        // 4095*4095 = 16769025 = 5037*3329 + 852
        vecs[6] = '{a: 12'd4095, b: 12'd4095, tag: 8'h77, exp_data: 12'd852,  exp_err: RANGE_EN};

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Table: one pair at a time, result appears two edges after acceptance
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].tag);
            check("lat_edge0_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check("lat_edge1_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_data", 32'(out_data), 32'(vecs[i].exp_data));
            check("vec_tag", 32'(out_tag), 32'(vecs[i].tag));
            check("vec_err", 32'(out_err), 32'(vecs[i].exp_err));
            @(posedge clk); #1;
            check("vec_drained", 32'(out_valid), 32'd0);
        end

        // Streaming: 1000 back-to-back pairs, one accepted per cycle
        start_cyc = cyc;
        start_out = n_out;
        for (int i = 0; i < 1000; i++) begin
            send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 8'(i % 256));
        end
        check("stream_cycles", 32'(cyc - start_cyc), 32'd1000);
        repeat (4) @(posedge clk);
        #1;
        check("stream_count", 32'(n_out - start_out), 32'd1000);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: capacity 3, then drain with same-edge refill
        out_ready = 1'b0;
        send(12'd100, 12'd200, 8'hA0);
        send(12'd300, 12'd400, 8'hA1);
        send(12'd500, 12'd600, 8'hA2);
        in_valid = 1'b1;
        in_a = 12'd700;
        in_b = 12'd800;
        in_tag = 8'hA3;
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_stall", 32'(in_ready), 32'd0);
        check("bp_first_data", 32'(out_data), 32'(12'((100 * 200) % Q)));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_drain", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Random valid/ready for 5000 cycles
        begin
            logic accepted;
            accepted = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                if (accepted) in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                if (!in_valid && ($urandom_range(0, 1) == 1)) begin
                    in_valid = 1'b1;
                    in_a = 12'($urandom_range(0, 4095));
                    in_b = 12'($urandom_range(0, 4095));
                    in_tag = 8'($urandom_range(0, 255));
                end
                @(negedge clk);
                accepted = in_valid && in_ready;
                @(posedge clk);
                #1;
            end
            if (accepted) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-flight: three in-flight operations are discarded
        out_ready = 1'b0;
        send(12'd11, 12'd22, 8'hB0);
        send(12'd33, 12'd44, 8'hB1);
        send(12'd55, 12'd66, 8'hB2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("mid_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Pipeline still works after the reset
        send(12'd3328, 12'd2, 8'hC0);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
